// File: rtl/data_ram_responder_pkg.sv
// data_ram_responder_pkg: shared FSM encoding and parameter defaults for the data RAM responder
package data_ram_responder_pkg;
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DUMP  = 2'd2,
        DONE  = 2'd3
    } state_t;
    localparam int ADDR_W_DEF    = 8;
    localparam int DUMP_BASE_DEF = 0;
    localparam int DUMP_LEN_DEF  = 256;
endpackage

// File: rtl/data_ram_responder_if.sv
// data_ram_responder_if: CPU data-bus and dump-stream signals of the data RAM responder
// master: CPU/sink side (drives address, write data, strobes, FINISH, DUMP_READY)
// slave : responder side (drives RAM_IN and the DUMP_* stream outputs)
interface data_ram_responder_if;
    logic [15:0] RAM_ADDR;
    logic [7:0]  RAM_OUT;
    logic        WRITE;
    logic [7:0]  RAM_IN;
    logic        FINISH;
    logic [7:0]  DUMP_DATA;
    logic        DUMP_VALID;
    logic        DUMP_READY;
    logic        DUMP_DONE;
    modport master (
        output RAM_ADDR, RAM_OUT, WRITE, FINISH, DUMP_READY,
        input  RAM_IN, DUMP_DATA, DUMP_VALID, DUMP_DONE
    );
    modport slave (
        input  RAM_ADDR, RAM_OUT, WRITE, FINISH, DUMP_READY,
        output RAM_IN, DUMP_DATA, DUMP_VALID, DUMP_DONE
    );
endinterface

// File: rtl/data_ram_responder_ram_byte_array.sv
// ram_byte_array: 2^AW byte array, one synchronous write port, two asynchronous read ports, no reset
// ports: clk; we/waddr/wdata write port; raddr_a/rdata_a CPU read; raddr_b/rdata_b dump read
module ram_byte_array #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [7:0]    rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [7:0]    rdata_b
);
    logic [7:0] mem [2**AW];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/data_ram_responder.sv
// data_ram_responder: CPU data RAM that streams a memory window out after the CPU signals FINISH
// ports: clk; reset (async, active-low); bus (slave modport) carrying the CPU
// data port (RAM_ADDR/RAM_OUT/WRITE/RAM_IN), FINISH and the DUMP_* ready/valid stream
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DUMP_BASE = DUMP_BASE_DEF,
    parameter int DUMP_LEN  = DUMP_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    data_ram_responder_if.slave   bus
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(DUMP_BASE);
    localparam logic [ADDR_W:0]   LEN  = (ADDR_W+1)'(DUMP_LEN);
    localparam logic [ADDR_W:0]   LAST = LEN - (ADDR_W+1)'(1);
    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W:0]     cnt;
    logic [7:0]          cpu_rd;
    logic [7:0]          dump_rd;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [ADDR_W-1:0]   dump_addr;
    assign cpu_addr  = bus.RAM_ADDR[ADDR_W-1:0];
    // DRAIN fetches the first byte; in DUMP the port looks one ahead so each handshake loads the next beat
    assign dump_addr = (state == DRAIN) ? BASE : ptr + ADDR_W'(1);
    ram_byte_array #(.AW(ADDR_W)) u_mem (
        .clk     (clk),
        .we      ((state == RUN) && bus.WRITE),
        .waddr   (cpu_addr),
        .wdata   (bus.RAM_OUT),
        .raddr_a (cpu_addr),
        .rdata_a (cpu_rd),
        .raddr_b (dump_addr),
        .rdata_b (dump_rd)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= RUN;
            ptr            <= '0;
            cnt            <= '0;
            bus.RAM_IN     <= '0;
            bus.DUMP_DATA  <= '0;
            bus.DUMP_VALID <= 1'b0;
            bus.DUMP_DONE  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    // write-first: a same-cycle write is what the CPU reads back
                    bus.RAM_IN <= bus.WRITE ? bus.RAM_OUT : cpu_rd;
                    if (bus.FINISH) state <= DRAIN;
                end
                DRAIN: begin
                    ptr           <= BASE;
                    cnt           <= '0;
                    bus.DUMP_DATA <= dump_rd;
                    if (LEN == '0) begin
                        state         <= DONE;
                        bus.DUMP_DONE <= 1'b1;
                    end else begin
                        state          <= DUMP;
                        bus.DUMP_VALID <= 1'b1;
                    end
                end
                DUMP: begin
                    if (bus.DUMP_READY) begin
                        ptr           <= ptr + ADDR_W'(1);
                        cnt           <= cnt + (ADDR_W+1)'(1);
                        bus.DUMP_DATA <= dump_rd;
                        if (cnt == LAST) begin
                            state          <= DONE;
                            bus.DUMP_VALID <= 1'b0;
                            bus.DUMP_DONE  <= 1'b1;
                        end
                    end
                end
                default: state <= DONE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_ram_responder.sv
// tb_data_ram_responder: scoreboard bench for data_ram_responder (DUMP_LEN=4 and DUMP_LEN=0 instances)
module tb_data_ram_responder;
    import data_ram_responder_pkg::*;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_z = 1'b1;
    logic rd_a = 1'b0, rd_a_seen = 1'b0;
    logic rd_z = 1'b0, rd_z_seen = 1'b0;
    int total = 0;
    int bad = 0;
    logic [7:0] rqa[$];
    logic [7:0] rqz[$];
    logic [7:0] dq[$];
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    data_ram_responder_if ia ();
    data_ram_responder_if iz ();
    data_ram_responder #(.ADDR_W(8), .DUMP_BASE(0), .DUMP_LEN(4)) u_a (
        .clk(clk), .reset(rst_a), .bus(ia.slave));
    data_ram_responder #(.ADDR_W(8), .DUMP_BASE(0), .DUMP_LEN(0)) u_z (
        .clk(clk), .reset(rst_z), .bus(iz.slave));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        rd_a_seen <= rd_a;
        rd_z_seen <= rd_z;
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic a_cycle(input logic [15:0] ad, input logic [7:0] d, input logic w,
                           input logic rd, input logic [7:0] exp);
        ia.RAM_ADDR = ad;
        ia.RAM_OUT  = d;
        ia.WRITE    = w;
        rd_a        = rd;
        if (rd) rqa.push_back(exp);
        tick();
        rd_a     = 1'b0;
        ia.WRITE = 1'b0;
    endtask
    always @(negedge clk) begin
        if (rd_a_seen) begin
            if (rqa.size() == 0) chk("a_rd_unexpected", 32'(ia.RAM_IN), 32'hFFFF);
            else chk("a_ram_in", 32'(ia.RAM_IN), 32'(rqa.pop_front()));
        end
        if (rd_z_seen) begin
            if (rqz.size() == 0) chk("z_rd_unexpected", 32'(iz.RAM_IN), 32'hFFFF);
            else chk("z_ram_in", 32'(iz.RAM_IN), 32'(rqz.pop_front()));
        end
        if (ia.DUMP_VALID) begin
            if (dq.size() == 0) chk("a_extra_beat", 32'(ia.DUMP_DATA), 32'hFFFF);
            else begin
                chk("a_dump_data", 32'(ia.DUMP_DATA), 32'(dq[0]));
                if (ia.DUMP_READY) void'(dq.pop_front());
            end
        end
        if (iz.DUMP_VALID) chk("z_valid_never", 32'(iz.DUMP_VALID), 32'd0);
    end
    initial begin
        ia.RAM_ADDR = '0; ia.RAM_OUT = '0; ia.WRITE = 1'b0; ia.FINISH = 1'b0; ia.DUMP_READY = 1'b0;
        iz.RAM_ADDR = '0; iz.RAM_OUT = '0; iz.WRITE = 1'b0; iz.FINISH = 1'b0; iz.DUMP_READY = 1'b0;
        #1;
        rst_a = 1'b0;
        rst_z = 1'b0;
        #1;
        chk("rst_ram_in", 32'(ia.RAM_IN), 32'd0);
        chk("rst_dump_data", 32'(ia.DUMP_DATA), 32'd0);
        chk("rst_valid", 32'(ia.DUMP_VALID), 32'd0);
        chk("rst_done", 32'(ia.DUMP_DONE), 32'd0);
        chk("rst_state", 32'(u_a.state), 32'(RUN));
        tick();
        tick();
        rst_a = 1'b1;
        rst_z = 1'b1;
        tick();
        a_cycle(16'h0010, 8'hA5, 1'b1, 1'b0, 8'h00);
        a_cycle(16'h0010, 8'h00, 1'b0, 1'b1, 8'hA5);
        a_cycle(16'h0020, 8'h3C, 1'b1, 1'b1, 8'h3C);
        a_cycle(16'h0105, 8'h77, 1'b1, 1'b0, 8'h00);
        a_cycle(16'h0005, 8'h00, 1'b0, 1'b1, 8'h77);
        a_cycle(16'h0020, 8'h00, 1'b0, 1'b1, 8'h3C);
        for (int i = 0; i < 3; i++) a_cycle(16'(i), 8'(i), 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) dq.push_back(8'(i));
        ia.RAM_ADDR = 16'h0003;
        ia.RAM_OUT  = 8'h03;
        ia.WRITE    = 1'b1;
        ia.FINISH   = 1'b1;
        tick();
        ia.WRITE  = 1'b0;
        ia.FINISH = 1'b0;
        chk("drain_valid", 32'(ia.DUMP_VALID), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            ia.DUMP_READY = pat[i];
            if (i == 1) begin
                ia.RAM_ADDR = 16'h0002;
                ia.RAM_OUT  = 8'hEE;
                ia.WRITE    = 1'b1;
            end
            tick();
            ia.WRITE = 1'b0;
        end
        ia.DUMP_READY = 1'b0;
        chk("done_flag", 32'(ia.DUMP_DONE), 32'd1);
        chk("done_valid", 32'(ia.DUMP_VALID), 32'd0);
        chk("beats_left", 32'(dq.size()), 32'd0);
        chk("ram_in_held", 32'(ia.RAM_IN), 32'h03);
        rst_a = 1'b0;
        #1;
        chk("rst2_done", 32'(ia.DUMP_DONE), 32'd0);
        tick();
        rst_a = 1'b1;
        tick();
        dq.push_back(8'h00);
        dq.push_back(8'h01);
        ia.FINISH = 1'b1;
        tick();
        ia.FINISH     = 1'b0;
        ia.DUMP_READY = 1'b1;
        tick();
        tick();
        tick();
        rst_a = 1'b0;
        #1;
        chk("abort_valid", 32'(ia.DUMP_VALID), 32'd0);
        chk("abort_state", 32'(u_a.state), 32'(RUN));
        tick();
        rst_a         = 1'b1;
        ia.DUMP_READY = 1'b0;
        tick();
        chk("abort_beats", 32'(dq.size()), 32'd0);
        a_cycle(16'h0003, 8'h00, 1'b0, 1'b1, 8'h03);
        iz.RAM_ADDR = 16'h0000;
        iz.RAM_OUT  = 8'h5A;
        iz.WRITE    = 1'b1;
        tick();
        iz.WRITE  = 1'b0;
        iz.FINISH = 1'b1;
        tick();
        iz.FINISH = 1'b0;
        chk("z_done_early", 32'(iz.DUMP_DONE), 32'd0);
        tick();
        chk("z_done", 32'(iz.DUMP_DONE), 32'd1);
        iz.RAM_OUT = 8'h99;
        iz.WRITE   = 1'b1;
        tick();
        iz.WRITE = 1'b0;
        tick();
        chk("z_done_sticky", 32'(iz.DUMP_DONE), 32'd1);
        rst_z = 1'b0;
        tick();
        rst_z = 1'b1;
        tick();
        rd_z = 1'b1;
        rqz.push_back(8'h5A);
        tick();
        rd_z = 1'b0;
        tick();
        chk("reads_left", 32'(rqa.size() + rqz.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
